// File: rtl/wash_setting_input.sv
`default_nettype none
// ============================================================================
// Module      : wash_setting_input
// Description : Washing-machine panel key front end. Synchronizes and
//               debounces five panel keys, edits the 26-bit program-setting
//               word while the controller is in the set state, and raises
//               start / empty-program pulses.
// Option      : WASH_KEY_REPEAT_EN - auto-repeat for held up/down keys.
// Revision    : 1.0 - initial release
// ============================================================================
module wash_setting_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic        cp,
  input  logic        rst_n,
  input  logic [2:0]  state,
  input  logic        keyNext,
  input  logic        keyUp,
  input  logic        keyDown,
  input  logic        keyClear,
  input  logic        keyStart,
  output logic [25:0] source,
  output logic [2:0]  cursor,
  output logic        startReq,
  output logic        emptyErr
);

  localparam int          NUM_KEYS  = 5;
  localparam int          KEY_NEXT  = 0;
  localparam int          KEY_UP    = 1;
  localparam int          KEY_DOWN  = 2;
  localparam int          KEY_CLEAR = 3;
  localparam int          KEY_START = 4;
  localparam int          DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0]  ST_SET    = 3'd2;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rep;
  logic [NUM_KEYS-1:0] ev;

  assign key_raw = {keyStart, keyClear, keyDown, keyUp, keyNext};

  // --------------------------------------------------------------------------
  // Per-key synchronizer, debouncer and rising-edge press detector
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [1:0]      sync;
    logic            deb;
    logic            deb_q;
    logic [DB_W-1:0] cnt;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge cp or negedge rst_n) begin
      if (!rst_n) begin
        sync  <= 2'b00;
        deb   <= 1'b0;
        deb_q <= 1'b0;
        cnt   <= '0;
      end else begin
        sync  <= {sync[0], key_raw[k]};
        deb_q <= deb;
        if (sync[1] != deb) begin
          if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb <= ~deb;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign press[k] = deb & ~deb_q;
  end

  // --------------------------------------------------------------------------
  // Optional auto-repeat on held up/down keys
  // --------------------------------------------------------------------------
`ifdef WASH_KEY_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

  for (genvar r = KEY_UP; r <= KEY_DOWN; r++) begin : g_rep
    logic [RP_W-1:0] rep_cnt;
    logic            held;

    assign held   = g_key[r].deb;
    assign rep[r] = held & ~press[r] & (rep_cnt == RP_W'(REPEAT_CYCLES - 1));

    // Timer restarts on release and on the key's own initial press
    always_ff @(posedge cp or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt <= '0;
      end else if (!held || press[r] || rep[r]) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign rep[KEY_NEXT]  = 1'b0;
  assign rep[KEY_CLEAR] = 1'b0;
  assign rep[KEY_START] = 1'b0;
`else
  assign rep = '0;
`endif

  assign ev = press | rep;

  // --------------------------------------------------------------------------
  // Field edit: locate the field under the cursor and compute the new word
  // --------------------------------------------------------------------------
  logic [4:0]  fld_lsb;
  logic [3:0]  fld_max;
  logic [3:0]  fld_val;
  logic [3:0]  fld_new;
  logic [25:0] edit_word;

  // Up/down wrap within the field; other fields are masked through unchanged
  always_comb begin
    fld_lsb = 5'd0;
    fld_max = 4'd7;
    case (cursor)
      3'd0: begin fld_lsb = 5'd0;  fld_max = 4'd7;  end
      3'd1: begin fld_lsb = 5'd3;  fld_max = 4'd7;  end
      3'd2: begin fld_lsb = 5'd6;  fld_max = 4'd15; end
      3'd3: begin fld_lsb = 5'd10; fld_max = 4'd7;  end
      3'd4: begin fld_lsb = 5'd13; fld_max = 4'd7;  end
      3'd5: begin fld_lsb = 5'd16; fld_max = 4'd7;  end
      3'd6: begin fld_lsb = 5'd19; fld_max = 4'd15; end
      default: begin fld_lsb = 5'd23; fld_max = 4'd7; end
    endcase
    fld_val = 4'(source >> fld_lsb) & fld_max;
    if (ev[KEY_UP]) begin
      fld_new = (fld_val == fld_max) ? 4'd0 : fld_val + 4'd1;
    end else begin
      fld_new = (fld_val == 4'd0) ? fld_max : fld_val - 4'd1;
    end
    edit_word = (source & ~({22'd0, fld_max} << fld_lsb))
              | ({22'd0, fld_new} << fld_lsb);
  end

  // --------------------------------------------------------------------------
  // Prioritized event execution, gated by the set state
  // --------------------------------------------------------------------------
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      source   <= 26'd0;
      cursor   <= 3'd0;
      startReq <= 1'b0;
      emptyErr <= 1'b0;
    end else begin
      startReq <= 1'b0;
      emptyErr <= 1'b0;
      if (state == ST_SET) begin
        if (ev[KEY_CLEAR]) begin
          source <= 26'd0;
          cursor <= 3'd0;
        end else if (ev[KEY_START]) begin
          if (source != 26'd0) begin
            startReq <= 1'b1;
          end else begin
            emptyErr <= 1'b1;
          end
        end else if (ev[KEY_NEXT]) begin
          cursor <= cursor + 3'd1;
        end else if (ev[KEY_UP] || ev[KEY_DOWN]) begin
          source <= edit_word;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wash_setting_input.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_setting_input
// Description : Directed self-checking bench for wash_setting_input
//               (DEBOUNCE_CYCLES = 4, REPEAT_CYCLES = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_setting_input;

  logic        cp;
  logic        rst_n;
  logic [2:0]  state;
  logic [4:0]  keys;   // {start, clear, down, up, next}
  logic [25:0] source;
  logic [2:0]  cursor;
  logic        startReq;
  logic        emptyErr;

  int total;
  int bad;
  int sr_cnt;
  int ee_cnt;
  int both_cnt;

  localparam logic [4:0] K_NEXT  = 5'b00001;
  localparam logic [4:0] K_UP    = 5'b00010;
  localparam logic [4:0] K_DOWN  = 5'b00100;
  localparam logic [4:0] K_CLEAR = 5'b01000;
  localparam logic [4:0] K_START = 5'b10000;

  wash_setting_input #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut (
    .cp      (cp),
    .rst_n   (rst_n),
    .state   (state),
    .keyNext (keys[0]),
    .keyUp   (keys[1]),
    .keyDown (keys[2]),
    .keyClear(keys[3]),
    .keyStart(keys[4]),
    .source  (source),
    .cursor  (cursor),
    .startReq(startReq),
    .emptyErr(emptyErr)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // Pulse counters sampled on the inactive edge
  always @(negedge cp) begin
    if (startReq) sr_cnt++;
    if (emptyErr) ee_cnt++;
    if (startReq && emptyErr) both_cnt++;
  end

  task automatic clear_counts();
    sr_cnt   = 0;
    ee_cnt   = 0;
    both_cnt = 0;
  endtask

  // Hold a key pattern for 8 cycles, then release and let it debounce low
  task automatic press(input logic [4:0] mask);
    keys = mask;
    repeat (8) @(negedge cp);
    keys = 5'b0;
    repeat (8) @(negedge cp);
  endtask

  task automatic test_reset();
    total++;
    if (source !== 26'd0) begin
      bad++; $display("FAIL reset_source got=%h want=%h", source, 26'd0);
    end
    total++;
    if (cursor !== 3'd0) begin
      bad++; $display("FAIL reset_cursor got=%0d want=0", cursor);
    end
    total++;
    if ({startReq, emptyErr} !== 2'b00) begin
      bad++; $display("FAIL reset_pulses got=%b want=00", {startReq, emptyErr});
    end
  endtask

  task automatic test_up_latency();
    // First press: unchanged after edge 6, updated at edge 7
    keys = K_UP;
    repeat (6) @(negedge cp);
    total++;
    if (source !== 26'd0) begin
      bad++; $display("FAIL latency_early got=%h want=%h", source, 26'd0);
    end
    @(negedge cp);
    total++;
    if (source !== 26'd1) begin
      bad++; $display("FAIL latency_edge7 got=%h want=%h", source, 26'd1);
    end
    @(negedge cp);
    keys = 5'b0;
    repeat (8) @(negedge cp);
    press(K_UP);
    press(K_UP);
    total++;
    if (source !== 26'h0000003) begin
      bad++; $display("FAIL up_x3 got=%h want=%h", source, 26'h0000003);
    end
  endtask

  task automatic test_field2();
    press(K_CLEAR);
    press(K_NEXT);
    press(K_NEXT);
    press(K_DOWN);
    total++;
    if (source !== 26'h00003C0) begin
      bad++; $display("FAIL field2_down got=%h want=%h", source, 26'h00003C0);
    end
    press(K_UP);
    total++;
    if (source !== 26'h0000000) begin
      bad++; $display("FAIL field2_up_wrap got=%h want=%h", source, 26'h0000000);
    end
    // Down on field 0 from 0 wraps to 7
    press(K_CLEAR);
    press(K_DOWN);
    total++;
    if (source !== 26'h0000007) begin
      bad++; $display("FAIL field0_down_wrap got=%h want=%h", source, 26'h0000007);
    end
  endtask

  task automatic test_cursor_wrap();
    press(K_CLEAR);
    for (int i = 0; i < 7; i++) press(K_NEXT);
    total++;
    if (cursor !== 3'd7) begin
      bad++; $display("FAIL cursor_7 got=%0d want=7", cursor);
    end
    press(K_NEXT);
    total++;
    if (cursor !== 3'd0) begin
      bad++; $display("FAIL cursor_wrap got=%0d want=0", cursor);
    end
    // 3-cycle glitch is shorter than the debounce window
    keys = K_UP;
    repeat (3) @(negedge cp);
    keys = 5'b0;
    repeat (12) @(negedge cp);
    total++;
    if (source !== 26'd0) begin
      bad++; $display("FAIL glitch got=%h want=%h", source, 26'd0);
    end
  endtask

  task automatic test_start();
    clear_counts();
    press(K_START);
    total++;
    if ({sr_cnt, ee_cnt} !== {32'd0, 32'd1}) begin
      bad++; $display("FAIL start_empty got sr=%0d ee=%0d want sr=0 ee=1", sr_cnt, ee_cnt);
    end
    for (int i = 0; i < 7; i++) press(K_NEXT);
    press(K_UP);
    total++;
    if (source !== 26'h0800000) begin
      bad++; $display("FAIL field7_set got=%h want=%h", source, 26'h0800000);
    end
    clear_counts();
    press(K_START);
    total++;
    if ({sr_cnt, ee_cnt, both_cnt} !== {32'd1, 32'd0, 32'd0}) begin
      bad++; $display("FAIL start_ok got sr=%0d ee=%0d both=%0d want 1/0/0", sr_cnt, ee_cnt, both_cnt);
    end
    total++;
    if (source !== 26'h0800000) begin
      bad++; $display("FAIL start_keeps_source got=%h want=%h", source, 26'h0800000);
    end
  endtask

  task automatic test_priority();
    // cursor=7, source=0x0800000 from previous test
    press(K_NEXT | K_UP);
    total++;
    if ({cursor, source} !== {3'd0, 26'h0800000}) begin
      bad++; $display("FAIL prio_next_up got c=%0d s=%h want c=0 s=%h", cursor, source, 26'h0800000);
    end
    press(K_UP | K_DOWN);
    total++;
    if (source !== 26'h0800001) begin
      bad++; $display("FAIL prio_up_down got=%h want=%h", source, 26'h0800001);
    end
    clear_counts();
    press(K_START | K_NEXT);
    total++;
    if ({cursor, sr_cnt} !== {3'd0, 32'd1}) begin
      bad++; $display("FAIL prio_start_next got c=%0d sr=%0d want c=0 sr=1", cursor, sr_cnt);
    end
    press(K_NEXT);
    clear_counts();
    press(K_CLEAR | K_UP | K_START);
    total++;
    if ({source, cursor, sr_cnt, ee_cnt} !== {26'd0, 3'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL prio_clear got s=%h c=%0d sr=%0d ee=%0d want 0/0/0/0", source, cursor, sr_cnt, ee_cnt);
    end
  endtask

  task automatic test_state_gate();
    press(K_UP);                       // source = 1
    state = 3'd3;
    press(K_UP);
    press(K_NEXT);
    total++;
    if ({source, cursor} !== {26'd1, 3'd0}) begin
      bad++; $display("FAIL gate_run got s=%h c=%0d want s=1 c=0", source, cursor);
    end
    // Key already held when entering the set state gives no event
    keys = K_UP;
    repeat (10) @(negedge cp);
    state = 3'd2;
    repeat (6) @(negedge cp);
    keys = 5'b0;
    repeat (8) @(negedge cp);
    total++;
    if (source !== 26'd1) begin
      bad++; $display("FAIL gate_held got=%h want=%h", source, 26'd1);
    end
  endtask

  task automatic test_reset_mid();
    press(K_NEXT);                     // cursor = 1
    keys = K_UP;
    repeat (4) @(negedge cp);          // debounce in progress
    rst_n = 1'b0;
    #1;
    total++;
    if ({source, cursor} !== {26'd0, 3'd0}) begin
      bad++; $display("FAIL async_reset got s=%h c=%0d want 0/0", source, cursor);
    end
    keys = 5'b0;
    repeat (2) @(negedge cp);
    rst_n = 1'b1;
    clear_counts();
    repeat (15) @(negedge cp);
    total++;
    if ({source, cursor, sr_cnt, ee_cnt} !== {26'd0, 3'd0, 32'd0, 32'd0}) begin
      bad++; $display("FAIL reset_mid got s=%h c=%0d sr=%0d ee=%0d want 0", source, cursor, sr_cnt, ee_cnt);
    end
    press(K_UP);
    total++;
    if (source !== 26'd1) begin
      bad++; $display("FAIL after_reset_press got=%h want=%h", source, 26'd1);
    end
  endtask

`ifdef WASH_KEY_REPEAT_EN
  task automatic test_repeat();
    press(K_CLEAR);
    keys = K_UP;
    repeat (31) @(negedge cp);
    keys = 5'b0;
    repeat (15) @(negedge cp);
    total++;
    if (source !== 26'd4) begin
      bad++; $display("FAIL repeat got=%h want=%h", source, 26'd4);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    clear_counts();
    rst_n = 1'b0;
    state = 3'd0;
    keys  = 5'b0;
    repeat (3) @(negedge cp);
    test_reset();
    rst_n = 1'b1;
    state = 3'd2;
    @(negedge cp);
    test_up_latency();
    test_field2();
    test_cursor_wrap();
    test_start();
    test_priority();
    test_state_gate();
    test_reset_mid();
`ifdef WASH_KEY_REPEAT_EN
    test_repeat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
